// File: rtl/pll_reset_sequencer.sv
// Turns an asynchronous PLL lock indicator into a qualified system reset and core run enable.
// Lock loss re-runs the sequence. Sticky and count status are kept for CSR readback.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int RUN_DELAY_CYCLES   = 4,
  parameter int COUNT_WIDTH        = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  input  logic                   ext_reset_req,
  input  logic                   clear_status,
  output logic                   sys_reset_n,
  output logic                   core_run,
  output logic                   lock_lost,
  output logic [COUNT_WIDTH-1:0] relock_count,
  output logic [2:0]             state
);

  localparam logic [2:0] WAIT_LOCK   = 3'd0;
  localparam logic [2:0] LOCK_FILTER = 3'd1;
  localparam logic [2:0] HOLD_RESET  = 3'd2;
  localparam logic [2:0] RELEASE     = 3'd3;
  localparam logic [2:0] RUN         = 3'd4;

  localparam int MAX_LH = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES
                                                                   : RESET_HOLD_CYCLES;
  localparam int MAX_P  = (MAX_LH > RUN_DELAY_CYCLES) ? MAX_LH : RUN_DELAY_CYCLES;
  localparam int CNT_W  = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_DELAY_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [2:0]             state_nxt;
  logic                   loss;

  assign lk = sync_q[SYNC_STAGES-1];

  // cnt counts lk-high edges in LOCK_FILTER, and elapsed cycles in HOLD_RESET/RELEASE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss      = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lk) begin
          if (LOCK_STABLE_CYCLES == 1) begin
            state_nxt = HOLD_RESET;
            cnt_nxt   = '0;
          end else begin
            state_nxt = LOCK_FILTER;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      LOCK_FILTER: begin
        if (!lk) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == LOCK_LAST) begin
          state_nxt = HOLD_RESET;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLD_RESET: begin
        if (!lk) begin
          loss      = 1'b1;
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!lk) begin
          loss      = 1'b1;
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (ext_reset_req) begin
          state_nxt = HOLD_RESET;
          cnt_nxt   = '0;
        end else if (cnt == RUN_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lk) begin
          loss      = 1'b1;
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (ext_reset_req) begin
          state_nxt = HOLD_RESET;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      state       <= WAIT_LOCK;
      cnt         <= '0;
      sys_reset_n <= 1'b0;
      core_run    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sys_reset_n <= (state_nxt == RELEASE) || (state_nxt == RUN);
      core_run    <= (state_nxt == RUN);
    end
  end

  // A lock-loss event overrides a same-cycle clear, so the count restarts at one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_lost    <= 1'b0;
      relock_count <= '0;
    end else if (loss) begin
      lock_lost <= 1'b1;
      if (clear_status)
        relock_count <= COUNT_WIDTH'(1);
      else if (!(&relock_count))
        relock_count <= relock_count + COUNT_WIDTH'(1);
    end else if (clear_status) begin
      lock_lost    <= 1'b0;
      relock_count <= '0;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed latency/event scenarios plus randomized lock,
// request and clear traffic, all checked against a lock-age reference model.
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int LOCK = 8;
  localparam int HOLD = 4;
  localparam int RUND = 2;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          ext_reset_req = 1'b0;
  logic          clear_status = 1'b0;
  logic          sys_reset_n;
  logic          core_run;
  logic          lock_lost;
  logic [CW-1:0] relock_count;
  logic [2:0]    state;

  pll_reset_sequencer #(
    .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(LOCK), .RESET_HOLD_CYCLES(HOLD),
    .RUN_DELAY_CYCLES(RUND), .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .pll_locked(pll_locked),
    .ext_reset_req(ext_reset_req), .clear_status(clear_status),
    .sys_reset_n(sys_reset_n), .core_run(core_run), .lock_lost(lock_lost),
    .relock_count(relock_count), .state(state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: k = number of consecutive qualified lk-high edges (lock age); outputs follow from k.
  int k = 0;
  int m_cnt = 0;
  bit m_lost = 1'b0;
  bit m_lk;
  bit pl_q[$];
  bit chk_en = 1'b0;

  function automatic void model_reset();
    k = 0; m_cnt = 0; m_lost = 1'b0; pl_q.delete();
  endfunction

  function automatic void model_update();
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_lk = (pl_q.size() >= SYNC) ? pl_q[pl_q.size() - SYNC] : 1'b0;
    pl_q.push_back(pll_locked);
    if (pl_q.size() > 8) void'(pl_q.pop_front());
    if (clear_status) begin
      m_cnt = 0; m_lost = 1'b0;
    end
    if (!m_lk) begin
      if (k >= LOCK) begin
        m_lost = 1'b1;
        m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
      end
      k = 0;
    end else if (ext_reset_req && k >= LOCK + HOLD) begin
      k = LOCK;
    end else if (k < LOCK + HOLD + RUND) begin
      k++;
    end
  endfunction

  function automatic int exp_state(int age);
    if (age == 0) return 0;
    if (age < LOCK) return 1;
    if (age < LOCK + HOLD) return 2;
    if (age < LOCK + HOLD + RUND) return 3;
    return 4;
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      chk("m_sys_reset_n", sys_reset_n, (k >= LOCK + HOLD) ? 1 : 0);
      chk("m_core_run", core_run, (k >= LOCK + HOLD + RUND) ? 1 : 0);
      chk("m_state", state, exp_state(k));
      chk("m_lock_lost", lock_lost, m_lost);
      chk("m_relock_count", relock_count, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic wait_sys(input logic val, output int n);
    n = 0;
    while (sys_reset_n !== val && n < 200) begin
      tick();
      n++;
    end
  endtask

  int n;
  int m;
  bit saw_high;

  initial begin
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    chk("rst_sys_reset_n", sys_reset_n, 0);
    chk("rst_core_run", core_run, 0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_relock_count", relock_count, 0);
    chk("rst_state", state, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Power-up latency
    pll_locked = 1'b1;
    wait_sys(1'b1, n);
    chk("pwr_sys_latency", n, 14);
    m = n;
    while (core_run !== 1'b1 && m < 200) begin tick(); m++; end
    chk("pwr_run_latency", m, 16);
    chk("pwr_state", state, 4);

    // Lock loss in RUN
    tick();
    pll_locked = 1'b0;
    wait_sys(1'b0, n);
    chk("loss_latency", n, 3);
    chk("loss_core_run", core_run, 0);
    chk("loss_lock_lost", lock_lost, 1);
    chk("loss_relock_count", relock_count, 1);
    chk("loss_state", state, 0);

    // clear_status alone
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("clr_lock_lost", lock_lost, 0);
    chk("clr_relock_count", relock_count, 0);

    // Glitch: 5 cycles high, then low, then steady
    repeat (3) tick();
    saw_high = 1'b0;
    pll_locked = 1'b1;
    repeat (5) begin tick(); if (sys_reset_n) saw_high = 1'b1; end
    pll_locked = 1'b0;
    repeat (4) begin tick(); if (sys_reset_n) saw_high = 1'b1; end
    chk("glitch_sys_low", saw_high, 0);
    chk("glitch_state", state, 0);
    pll_locked = 1'b1;
    wait_sys(1'b1, n);
    chk("glitch_relock_latency", n, 14);
    chk("glitch_lock_lost", lock_lost, 0);
    repeat (3) tick();

    // ext_reset_req pulse in RUN
    chk("ext_pre_state", state, 4);
    ext_reset_req = 1'b1;
    tick();
    ext_reset_req = 1'b0;
    chk("ext_sys_low", sys_reset_n, 0);
    chk("ext_run_low", core_run, 0);
    chk("ext_state", state, 2);
    wait_sys(1'b1, n);
    chk("ext_low_cycles", n, 4);
    m = 0;
    while (core_run !== 1'b1 && m < 200) begin tick(); m++; end
    chk("ext_run_delay", m, 2);
    chk("ext_relock_count", relock_count, 0);

    // Lock drop and ext_reset_req seen on the same edge
    pll_locked = 1'b0;
    repeat (2) tick();
    ext_reset_req = 1'b1;
    tick();
    ext_reset_req = 1'b0;
    chk("simul_state", state, 0);
    chk("simul_sys", sys_reset_n, 0);
    chk("simul_relock_count", relock_count, 1);

    // clear_status on the same edge as a lock-loss event
    pll_locked = 1'b1;
    repeat (20) tick();
    pll_locked = 1'b0;
    repeat (2) tick();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("clrev_lock_lost", lock_lost, 1);
    chk("clrev_relock_count", relock_count, 1);

    // Saturation of relock_count
    repeat (300) begin
      pll_locked = 1'b1;
      repeat (17) tick();
      pll_locked = 1'b0;
      repeat (4) tick();
    end
    chk("sat_relock_count", relock_count, CMAX);
    chk("sat_lock_lost", lock_lost, 1);

    // Asynchronous reset during RELEASE
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    pll_locked = 1'b1;
    repeat (15) tick();
    chk("arst_pre_state", state, 3);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_sys", sys_reset_n, 0);
    chk("arst_run", core_run, 0);
    chk("arst_state", state, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    wait_sys(1'b1, n);
    chk("arst_restart_latency", n, 14);

    // Randomized traffic
    repeat (3000) begin
      if (pll_locked) begin
        if ($urandom_range(0, 99) < 2) pll_locked = 1'b0;
      end else begin
        if ($urandom_range(0, 99) < 12) pll_locked = 1'b1;
      end
      ext_reset_req = ($urandom_range(0, 19) == 0);
      clear_status  = ($urandom_range(0, 49) == 0);
      tick();
    end
    ext_reset_req = 1'b0;
    clear_status  = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
